seg_frame_scanner: RTL and testbench

SEG_FRAME_SCANNER -- requirements
Module: seg_frame_scanner

---
 rtl/seg_frame_scanner_pkg.sv | 84 ++++++++
 rtl/seg_tick_divider.sv | 57 +++++
 rtl/seg_frame_scanner.sv | 194 +++++++++++++++++++
 tb/tb_seg_frame_scanner.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_frame_scanner_pkg.sv
// -----------------------------------------------------------------------------
// seg_frame_scanner_pkg
//
// Shared parameters for the multiplexed seven-segment scanner.
//
// Contents:
//   - digit count and index width of the 8-digit display
//   - frame handshake state encoding
//   - blank pattern and character segment constants
//   - small helpers: digit one-hot decode and hex-to-segment lookup
//
// Segment bit order in every pattern is {dp, g, f, e, d, c, b, a}.
// A set bit means the segment is lit.
// -----------------------------------------------------------------------------
package seg_frame_scanner_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = 3;

    typedef logic [7:0]                       seg_pattern_t;
    typedef seg_pattern_t [NUM_DIGITS-1:0]    seg_frame_t;
    typedef logic [IDX_W-1:0]                 digit_idx_t;

    // A frame is either already on the display (IDLE) or waiting in
    // staging for the next frame boundary (PENDING).
    typedef enum logic {
        FRAME_IDLE    = 1'b0,
        FRAME_PENDING = 1'b1
    } frame_state_t;

    // Blank pattern: all segments dark.
    localparam seg_pattern_t SEG_NULL   = 8'h00;

    // Character patterns.
    localparam seg_pattern_t SEG_CHAR_0 = 8'h3F;
    localparam seg_pattern_t SEG_CHAR_1 = 8'h06;
    localparam seg_pattern_t SEG_CHAR_2 = 8'h5B;
    localparam seg_pattern_t SEG_CHAR_3 = 8'h4F;
    localparam seg_pattern_t SEG_CHAR_4 = 8'h66;
    localparam seg_pattern_t SEG_CHAR_5 = 8'h6D;
    localparam seg_pattern_t SEG_CHAR_6 = 8'h7D;
    localparam seg_pattern_t SEG_CHAR_7 = 8'h07;
    localparam seg_pattern_t SEG_CHAR_8 = 8'h7F;
    localparam seg_pattern_t SEG_CHAR_9 = 8'h6F;
    localparam seg_pattern_t SEG_CHAR_A = 8'h77;
    localparam seg_pattern_t SEG_CHAR_B = 8'h7C;
    localparam seg_pattern_t SEG_CHAR_C = 8'h39;
    localparam seg_pattern_t SEG_CHAR_D = 8'h5E;
    localparam seg_pattern_t SEG_CHAR_E = 8'h79;
    localparam seg_pattern_t SEG_CHAR_F = 8'h71;
    localparam seg_pattern_t SEG_DASH   = 8'h40;
    localparam seg_pattern_t SEG_DP     = 8'h80;

    // Active-high one-hot enable for the given digit position.
    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input digit_idx_t idx);
        return {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Convenience lookup for callers that build frames from hex nibbles.
    function automatic seg_pattern_t hex_to_seg(input logic [3:0] value);
        seg_pattern_t pat;
        case (value)
            4'h0:    pat = SEG_CHAR_0;
            4'h1:    pat = SEG_CHAR_1;
            4'h2:    pat = SEG_CHAR_2;
            4'h3:    pat = SEG_CHAR_3;
            4'h4:    pat = SEG_CHAR_4;
            4'h5:    pat = SEG_CHAR_5;
            4'h6:    pat = SEG_CHAR_6;
            4'h7:    pat = SEG_CHAR_7;
            4'h8:    pat = SEG_CHAR_8;
            4'h9:    pat = SEG_CHAR_9;
            4'hA:    pat = SEG_CHAR_A;
            4'hB:    pat = SEG_CHAR_B;
            4'hC:    pat = SEG_CHAR_C;
            4'hD:    pat = SEG_CHAR_D;
            4'hE:    pat = SEG_CHAR_E;
            4'hF:    pat = SEG_CHAR_F;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_tick_divider.sv
// -----------------------------------------------------------------------------
// seg_tick_divider
//
// Prescaler producing one tick per digit slot. Counts 0..DIV_CNT-1 while
// enabled; tick is high during the cycle the count sits at DIV_CNT-1, and the
// count wraps to 0 on that edge. While disabled the count is held at 0, so a
// re-enable always starts a full slot.
//
// Parameters:
//   DIV_CNT - clk cycles per tick (>= 1)
//
// Ports:
//   clk  in  1  rising-edge clock
//   rst  in  1  asynchronous active-high reset
//   en   in  1  count enable
//   tick out 1  slot tick (combinational from the count register)
// -----------------------------------------------------------------------------
module seg_tick_divider #(
    parameter int DIV_CNT = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W   = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_CNT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count and tick. Disabling forces the count back to zero rather
    // than freezing it mid-slot.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_frame_scanner.sv
// -----------------------------------------------------------------------------
// seg_frame_scanner
//
// Time-multiplexed driver for an 8-digit seven-segment display split into two
// 4-digit tube groups. A frame (eight segment patterns plus a blink mask) is
// accepted into staging on load and only moved onto the display at a frame
// boundary (digit 7 -> 0 wrap), so a frame is never shown half old, half new.
//
// Parameters:
//   DIV_CNT     - clk cycles per digit slot
//   BLINK_TICKS - digit-slot ticks per blink half-period
//
// Ports:
//   clk         in  1  rising-edge clock
//   rst         in  1  asynchronous active-high reset
//   en          in  1  scanning enable
//   load        in  1  accept data7..data0 and blink_mask into staging
//   data7..0    in  8  segment patterns, digit 7 leftmost
//   blink_mask  in  8  bit i makes digit i blink
//   load_ack    out 1  one-cycle pulse when a staged frame is committed
//   seg_en      out 8  one-hot digit enable, bit i for digit i
//   seg_outl    out 8  segments for the left group (digits 7..4)
//   seg_outr    out 8  segments for the right group (digits 3..0)
//
// All outputs are registered and follow the digit index by one cycle.
// -----------------------------------------------------------------------------
module seg_frame_scanner
    import seg_frame_scanner_pkg::*;
#(
    parameter int DIV_CNT     = 100000,
    parameter int BLINK_TICKS = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] data7,
    input  logic [7:0] data6,
    input  logic [7:0] data5,
    input  logic [7:0] data4,
    input  logic [7:0] data3,
    input  logic [7:0] data2,
    input  logic [7:0] data1,
    input  logic [7:0] data0,
    input  logic [7:0] blink_mask,
    output logic       load_ack,
    output logic [7:0] seg_en,
    output logic [7:0] seg_outl,
    output logic [7:0] seg_outr
);

    localparam int               BLK_W   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_TICKS - 1);

    logic             tick;
    logic             boundary_tick;
    logic             commit;

    digit_idx_t       idx_q,         idx_d;
    logic [BLK_W-1:0] blink_cnt_q,   blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;

    frame_state_t     frame_state_q, frame_state_d;
    seg_frame_t       stage_q,       stage_d;
    logic [7:0]       stage_blink_q, stage_blink_d;
    seg_frame_t       shadow_q,      shadow_d;
    logic [7:0]       shadow_blink_q, shadow_blink_d;

    logic             load_ack_q,    load_ack_d;
    logic [7:0]       seg_en_q,      seg_en_d;
    seg_pattern_t     seg_outl_q,    seg_outl_d;
    seg_pattern_t     seg_outr_q,    seg_outr_d;
    seg_pattern_t     cur_pat;

    // Digit-slot tick source.
    seg_tick_divider #(
        .DIV_CNT (DIV_CNT)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    // The tick that carries the index from 7 back to 0 closes a frame.
    assign boundary_tick = tick && (idx_q == digit_idx_t'(NUM_DIGITS - 1));

    // Digit index and blink phase. Both are parked at zero while scanning is
    // disabled so that a re-enable starts cleanly at digit 0, lit phase.
    always_comb begin
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (!en) begin
            idx_d         = '0;
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (tick) begin
            idx_d = idx_q + 1'b1;
            if (blink_cnt_q == BLK_MAX) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Frame handshake. A pending frame is committed at the frame boundary,
    // or straight away when scanning is off since nothing is being shown.
    // The load check comes after the commit so that a load landing on the
    // commit cycle commits the older staging and leaves the new frame
    // pending for the following boundary.
    always_comb begin
        frame_state_d  = frame_state_q;
        stage_d        = stage_q;
        stage_blink_d  = stage_blink_q;
        shadow_d       = shadow_q;
        shadow_blink_d = shadow_blink_q;
        load_ack_d     = 1'b0;
        commit         = (frame_state_q == FRAME_PENDING) && (boundary_tick || !en);

        if (commit) begin
            shadow_d       = stage_q;
            shadow_blink_d = stage_blink_q;
            load_ack_d     = 1'b1;
            frame_state_d  = FRAME_IDLE;
        end

        if (load) begin
            stage_d       = {data7, data6, data5, data4, data3, data2, data1, data0};
            stage_blink_d = blink_mask;
            frame_state_d = FRAME_PENDING;
        end
    end

    // Output decode for the current digit. Blinking blanks the segments only;
    // the digit enable keeps pulsing so the scan timing is unchanged.
    always_comb begin
        cur_pat    = shadow_q[idx_q];
        seg_en_d   = '0;
        seg_outl_d = SEG_NULL;
        seg_outr_d = SEG_NULL;
        if (blink_phase_q && shadow_blink_q[idx_q]) begin
            cur_pat = SEG_NULL;
        end
        if (en) begin
            seg_en_d = digit_onehot(idx_q);
            if (idx_q[IDX_W-1]) begin
                seg_outl_d = cur_pat;
            end else begin
                seg_outr_d = cur_pat;
            end
        end
    end

    // State and output registers. Reset discards any staged frame, so no
    // acknowledge is ever produced for a frame loaded before reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q          <= '0;
            blink_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            frame_state_q  <= FRAME_IDLE;
            stage_q        <= '0;
            stage_blink_q  <= '0;
            shadow_q       <= '0;
            shadow_blink_q <= '0;
            load_ack_q     <= 1'b0;
            seg_en_q       <= '0;
            seg_outl_q     <= SEG_NULL;
            seg_outr_q     <= SEG_NULL;
        end else begin
            idx_q          <= idx_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_phase_q  <= blink_phase_d;
            frame_state_q  <= frame_state_d;
            stage_q        <= stage_d;
            stage_blink_q  <= stage_blink_d;
            shadow_q       <= shadow_d;
            shadow_blink_q <= shadow_blink_d;
            load_ack_q     <= load_ack_d;
            seg_en_q       <= seg_en_d;
            seg_outl_q     <= seg_outl_d;
            seg_outr_q     <= seg_outr_d;
        end
    end

    assign load_ack = load_ack_q;
    assign seg_en   = seg_en_q;
    assign seg_outl = seg_outl_q;
    assign seg_outr = seg_outr_q;

endmodule

// File: tb/tb_seg_frame_scanner.sv
// -----------------------------------------------------------------------------
// tb_seg_frame_scanner
//
// Self-checking bench for seg_frame_scanner with DIV_CNT=4, BLINK_TICKS=8.
// The reference model tracks only how many enabled cycles have elapsed and
// derives slot, digit, frame boundary and blink phase from that count with
// plain division; frames move from staging to display per the handshake
// rules. Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_seg_frame_scanner;

    localparam int DIV   = 4;
    localparam int BLINK = 8;
    localparam int FRAME = 8 * DIV;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] data_in [8];
    logic [7:0] blink_mask;
    logic       load_ack;
    logic [7:0] seg_en;
    logic [7:0] seg_outl;
    logic [7:0] seg_outr;

    int          n_pass;
    int          n_total;
    int          ack_cnt;

    // Reference model state.
    int          pos;
    logic [7:0]  m_shadow [8];
    logic [7:0]  m_stage  [8];
    logic [7:0]  m_shadow_blink;
    logic [7:0]  m_stage_blink;
    bit          m_pend;

    logic [24:0] exp_out;
    logic [24:0] obs;

    seg_frame_scanner #(
        .DIV_CNT     (DIV),
        .BLINK_TICKS (BLINK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .data7      (data_in[7]),
        .data6      (data_in[6]),
        .data5      (data_in[5]),
        .data4      (data_in[4]),
        .data3      (data_in[3]),
        .data2      (data_in[2]),
        .data1      (data_in[1]),
        .data0      (data_in[0]),
        .blink_mask (blink_mask),
        .load_ack   (load_ack),
        .seg_en     (seg_en),
        .seg_outl   (seg_outl),
        .seg_outr   (seg_outr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        pos            = 0;
        m_pend         = 1'b0;
        m_shadow_blink = 8'h00;
        m_stage_blink  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m_shadow[i] = 8'h00;
            m_stage[i]  = 8'h00;
        end
    endtask

    // Predict what the next rising edge produces from the inputs now applied,
    // advance the model, then take the edge and sample the DUT.
    task automatic step();
        int         slot;
        int         digit;
        bit         phase;
        bit         boundary;
        bit         commit;
        logic [7:0] pat;
        logic [7:0] e_en;
        logic [7:0] e_l;
        logic [7:0] e_r;
        if (rst) begin
            exp_out = '0;
            model_clear();
        end else begin
            slot     = pos / DIV;
            digit    = slot % 8;
            phase    = ((slot / BLINK) % 2) == 1;
            boundary = en && ((pos % FRAME) == FRAME - 1);
            commit   = m_pend && (boundary || !en);
            pat      = (phase && m_shadow_blink[digit]) ? 8'h00 : m_shadow[digit];
            e_en     = en ? 8'(1 << digit) : 8'h00;
            e_l      = (en && digit >= 4) ? pat : 8'h00;
            e_r      = (en && digit < 4)  ? pat : 8'h00;
            exp_out  = {commit, e_en, e_l, e_r};
            if (commit) begin
                for (int i = 0; i < 8; i++) m_shadow[i] = m_stage[i];
                m_shadow_blink = m_stage_blink;
                m_pend         = 1'b0;
            end
            if (load) begin
                for (int i = 0; i < 8; i++) m_stage[i] = data_in[i];
                m_stage_blink = blink_mask;
                m_pend        = 1'b1;
            end
            pos = en ? pos + 1 : 0;
        end
        @(posedge clk);
        #1;
        obs = {load_ack, seg_en, seg_outl, seg_outr};
    endtask

    task automatic load_frame(input logic [7:0] mask);
        for (int i = 0; i < 8; i++) data_in[i] = 8'($urandom);
        blink_mask = mask;
        load       = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        obs = {load_ack, seg_en, seg_outl, seg_outr};
        n_total++;
        if (obs !== 25'h0) $display("[TB] FAIL reset_async got=%07h want=%07h", obs, 25'h0);
        else n_pass++;
        model_clear();
        for (int k = 0; k < 2; k++) begin
            step();
            n_total++;
            if (obs !== exp_out) $display("[TB] FAIL reset_hold got=%07h want=%07h", obs, exp_out);
            else n_pass++;
        end
        rst = 1'b0;
        en  = 1'b1;
    endtask

    task automatic test_scan();
        for (int i = 0; i < 8; i++) data_in[i] = 8'(1 << i);
        blink_mask = 8'h00;
        load       = 1'b1;
        step();
        n_total++;
        if (obs !== exp_out) $display("[TB] FAIL scan_first got=%07h want=%07h", obs, exp_out);
        else n_pass++;
        load = 1'b0;
        for (int k = 0; k < 2 * FRAME + 1; k++) begin
            step();
            n_total++;
            if (obs !== exp_out) $display("[TB] FAIL scan pos=%0d got=%07h want=%07h", pos, obs, exp_out);
            else n_pass++;
        end
    endtask

    task automatic test_load_mid_frame();
        for (int k = 0; k < FRAME && ((pos / DIV) % 8) != 3; k++) begin
            step();
            n_total++;
            if (obs !== exp_out) $display("[TB] FAIL mid_wait got=%07h want=%07h", obs, exp_out);
            else n_pass++;
        end
        ack_cnt = 0;
        load_frame(8'h00);
        for (int k = 0; k < FRAME + 8; k++) begin
            step();
            load = 1'b0;
            ack_cnt += int'(obs[24]);
            n_total++;
            if (obs !== exp_out) $display("[TB] FAIL mid_load pos=%0d got=%07h want=%07h", pos, obs, exp_out);
            else n_pass++;
        end
        n_total++;
        if (ack_cnt !== 1) $display("[TB] FAIL mid_ack_count got=%0d want=1", ack_cnt);
        else n_pass++;
    endtask

    task automatic test_double_load();
        ack_cnt = 0;
        for (int k = 0; k < FRAME && ((pos / DIV) % 8) != 1; k++) begin
            step();
            ack_cnt += int'(obs[24]);
            n_total++;
            if (obs !== exp_out) $display("[TB] FAIL dbl_wait got=%07h want=%07h", obs, exp_out);
            else n_pass++;
        end
        load_frame(8'h00);
        for (int k = 0; k < FRAME && (k == 0 || ((pos / DIV) % 8) != 5); k++) begin
            step();
            load = 1'b0;
            ack_cnt += int'(obs[24]);
            n_total++;
            if (obs !== exp_out) $display("[TB] FAIL dbl_a pos=%0d got=%07h want=%07h", pos, obs, exp_out);
            else n_pass++;
        end
        load_frame(8'h00);
        for (int k = 0; k < FRAME; k++) begin
            step();
            load = 1'b0;
            ack_cnt += int'(obs[24]);
            n_total++;
            if (obs !== exp_out) $display("[TB] FAIL dbl_b pos=%0d got=%07h want=%07h", pos, obs, exp_out);
            else n_pass++;
        end
        n_total++;
        if (ack_cnt !== 1) $display("[TB] FAIL dbl_ack_count got=%0d want=1", ack_cnt);
        else n_pass++;
    endtask

    task automatic test_load_at_commit();
        ack_cnt = 0;
        for (int k = 0; k < FRAME && ((pos / DIV) % 8) != 2; k++) begin
            step();
            ack_cnt += int'(obs[24]);
            n_total++;
            if (obs !== exp_out) $display("[TB] FAIL coin_wait got=%07h want=%07h", obs, exp_out);
            else n_pass++;
        end
        load_frame(8'h00);
        for (int k = 0; k < FRAME && (k == 0 || (pos % FRAME) != FRAME - 1); k++) begin
            step();
            load = 1'b0;
            ack_cnt += int'(obs[24]);
            n_total++;
            if (obs !== exp_out) $display("[TB] FAIL coin_x pos=%0d got=%07h want=%07h", pos, obs, exp_out);
            else n_pass++;
        end
        load_frame(8'h00);
        for (int k = 0; k < 2 * FRAME + 4; k++) begin
            step();
            load = 1'b0;
            ack_cnt += int'(obs[24]);
            n_total++;
            if (obs !== exp_out) $display("[TB] FAIL coin_y pos=%0d got=%07h want=%07h", pos, obs, exp_out);
            else n_pass++;
        end
        n_total++;
        if (ack_cnt !== 2) $display("[TB] FAIL coin_ack_count got=%0d want=2", ack_cnt);
        else n_pass++;
    endtask

    task automatic test_blink();
        load_frame(8'h04);
        data_in[2] = 8'hFF;
        for (int k = 0; k < 5 * FRAME; k++) begin
            step();
            load = 1'b0;
            n_total++;
            if (obs !== exp_out) $display("[TB] FAIL blink pos=%0d got=%07h want=%07h", pos, obs, exp_out);
            else n_pass++;
        end
    endtask

    task automatic test_enable();
        load_frame(8'h00);
        step();
        load = 1'b0;
        en   = 1'b0;
        n_total++;
        if (obs !== exp_out) $display("[TB] FAIL en_load got=%07h want=%07h", obs, exp_out);
        else n_pass++;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) load_frame(8'hA5);
            step();
            load = 1'b0;
            n_total++;
            if (obs !== exp_out) $display("[TB] FAIL en_off k=%0d got=%07h want=%07h", k, obs, exp_out);
            else n_pass++;
        end
        en = 1'b1;
        for (int k = 0; k < FRAME + 4; k++) begin
            step();
            n_total++;
            if (obs !== exp_out) $display("[TB] FAIL en_resume pos=%0d got=%07h want=%07h", pos, obs, exp_out);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_scan();
        load_frame(8'h00);
        step();
        load = 1'b0;
        for (int k = 0; k < 5; k++) step();
        rst = 1'b1;
        #2;
        obs = {load_ack, seg_en, seg_outl, seg_outr};
        n_total++;
        if (obs !== 25'h0) $display("[TB] FAIL rst_mid_async got=%07h want=%07h", obs, 25'h0);
        else n_pass++;
        model_clear();
        step();
        step();
        rst     = 1'b0;
        ack_cnt = 0;
        for (int k = 0; k < FRAME + 8; k++) begin
            step();
            ack_cnt += int'(obs[24]);
            n_total++;
            if (obs !== exp_out) $display("[TB] FAIL rst_restart pos=%0d got=%07h want=%07h", pos, obs, exp_out);
            else n_pass++;
        end
        n_total++;
        if (ack_cnt !== 0) $display("[TB] FAIL rst_ack_count got=%0d want=0", ack_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(15) == 0) load_frame(8'($urandom));
            if ($urandom_range(63) == 0) en = ~en;
            step();
            load = 1'b0;
            n_total++;
            if (obs !== exp_out) $display("[TB] FAIL random k=%0d got=%07h want=%07h", k, obs, exp_out);
            else n_pass++;
        end
        en = 1'b1;
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        ack_cnt    = 0;
        rst        = 1'b0;
        en         = 1'b0;
        load       = 1'b0;
        blink_mask = 8'h00;
        obs        = '0;
        exp_out    = '0;
        for (int i = 0; i < 8; i++) data_in[i] = 8'h00;
        model_clear();

        $display("[TB] starting seg_frame_scanner bench");
        test_reset();
        test_scan();
        test_load_mid_frame();
        test_double_load();
        test_load_at_commit();
        test_blink();
        test_enable();
        test_reset_mid_scan();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
